// File: rtl/uart_tx_ext_if.sv
// Frame-request, configuration and serial-line bundle for uart_tx_ext.
// The master drives requests and configuration; the slave drives status and the line.
interface uart_tx_ext_if #(
    parameter int DBIT_MAX = 8
);
    logic                s_tick;
    logic                tx_valid;
    logic [DBIT_MAX-1:0] din;
    logic [1:0]          data_bits;
    logic [1:0]          parity_mode;
    logic                stop_bits;
    logic                tx_ready;
    logic                tx_busy;
    logic                tx_done_tick;
    logic                tx;

    modport master (
        output s_tick, tx_valid, din, data_bits, parity_mode, stop_bits,
        input  tx_ready, tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  s_tick, tx_valid, din, data_bits, parity_mode, stop_bits,
        output tx_ready, tx_busy, tx_done_tick, tx
    );
endinterface

// File: rtl/uart_tx_ext.sv
// Configurable UART transmitter: 5-8 data bits, optional parity, 1 or 2 stop bits.
// Timing comes from an oversampling enable; every bit lasts OVERSAMPLE ticks.
module uart_tx_ext #(
    parameter int OVERSAMPLE = 16,
    parameter int DBIT_MAX   = 8
) (
    input  logic          clk,
    input  logic          reset_in,
    uart_tx_ext_if.slave  bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
    localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [BW-1:0]       last_q, last_d;
    logic [DBIT_MAX-1:0] sh_q, sh_d;
    logic                par_q, par_d;
    logic                pen_q, pen_d;
    logic                two_q, two_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [DBIT_MAX-1:0] mask;
    logic [DBIT_MAX-1:0] sh_nx;
    logic [BW-1:0]       last_in;
    logic                par_in;
    logic                tick_end;
    int                  nlen;

    // Requested length clamped to DBIT_MAX; upper din bits are masked out of parity
    always_comb begin
        nlen = int'(bus.data_bits) + 5;
        if (nlen > DBIT_MAX) nlen = DBIT_MAX;
        for (int i = 0; i < DBIT_MAX; i++) mask[i] = (i < nlen);
        last_in = BW'(nlen - 1);
        par_in  = (^(bus.din & mask)) ^ (bus.parity_mode == 2'b10);
    end

    assign sh_nx    = sh_q >> 1;
    assign tick_end = bus.s_tick && (tick_q == TLAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        last_d  = last_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pen_d   = pen_q;
        two_d   = two_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (state_q != IDLE && bus.s_tick)
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                    sh_d    = bus.din;
                    last_d  = last_in;
                    par_d   = par_in;
                    pen_d   = (bus.parity_mode == 2'b01) ||
                              (bus.parity_mode == 2'b10);
                    two_d   = bus.stop_bits;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick_end) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (tick_end) begin
                    sh_d = sh_nx;
                    if (bit_q == last_q) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                        tx_d    = pen_q ? par_q : 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = sh_nx[0];
                    end
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // bit counter doubles as the stop-bit counter for two stop bits
                if (tick_end) begin
                    if (two_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            two_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            two_q   <= two_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_ready     = (state_q == IDLE);
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_ext.sv
// Self-checking bench for uart_tx_ext: directed frame table, hand-written
// back-to-back / reset sequences and random frames against a bit-list model.
module tb_uart_tx_ext;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset_in = 1'b0;
    always #5 clk = ~clk;

    uart_tx_ext_if #(.DBIT_MAX(8)) bus();

    uart_tx_ext #(.OVERSAMPLE(OS), .DBIT_MAX(8)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] db;
        logic [1:0] pm;
        logic       sb;
        int         ticks;
        int         par;
        int         gap_max;
        int         long_gap;
        bit         noise;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic t);
        bus.s_tick = t;
        @(posedge clk);
        #1;
        bus.s_tick = 1'b0;
    endtask

    // Frame as a list of bit-period values: start, data LSB first, parity, stops
    function automatic void model(input logic [7:0] d, input logic [1:0] db,
                                  input logic [1:0] pm, input logic sb,
                                  output logic [15:0] bits, output int nb);
        int  n;
        logic p;
        n    = 5 + int'(db);
        bits = '1;
        bits[0] = 1'b0;
        nb = 1;
        p  = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[nb] = d[i];
            p = p ^ d[i];
            nb++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            bits[nb] = (pm == 2'b10) ? ~p : p;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (sb) begin
            bits[nb] = 1'b1;
            nb++;
        end
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic [1:0] db,
                             input logic [1:0] pm, input logic sb,
                             input int exp_ticks, input int exp_par,
                             input int gap_max, input int long_gap,
                             input bit noise, input bit hold_next,
                             input logic [7:0] next_d, input string nm,
                             output int waited);
        logic [15:0] bits;
        logic [15:0] act;
        int nb, k, errs, bound, g;
        logic prev;
        model(d, db, pm, sb, bits, nb);
        act = '0;
        waited = 0;
        while (!bus.tx_ready && waited < 5000) begin
            step(1'b0);
            waited++;
        end
        chk({nm, " ready"}, int'(bus.tx_ready), 1);
        bus.tx_valid    = 1'b1;
        bus.din         = d;
        bus.data_bits   = db;
        bus.parity_mode = pm;
        bus.stop_bits   = sb;
        step(1'b0);
        chk({nm, " start"}, int'({bus.tx, bus.tx_busy}), 1);
        if (hold_next) bus.din = next_d;
        else bus.tx_valid = 1'b0;
        errs  = 0;
        k     = 0;
        bound = nb * OS + 4 * OS;
        while (!bus.tx_done_tick && k < bound) begin
            if (k / OS >= nb) errs++;
            else if (bus.tx !== bits[k / OS]) errs++;
            if (k % OS == OS / 2 && k / OS < 16) act[k / OS] = bus.tx;
            if (noise) begin
                bus.tx_valid    = 1'($urandom_range(1, 0));
                bus.din         = 8'($urandom);
                bus.data_bits   = 2'($urandom);
                bus.parity_mode = 2'($urandom);
                bus.stop_bits   = 1'($urandom);
            end
            g = (k == long_gap) ? 50 : int'($urandom_range(gap_max, 0));
            for (int j = 0; j < g; j++) begin
                prev = bus.tx;
                step(1'b0);
                if (bus.tx !== prev || bus.tx_done_tick) errs++;
            end
            step(1'b1);
            k++;
        end
        chk({nm, " ticks"}, k, exp_ticks);
        chk({nm, " bits"}, errs, 0);
        chk({nm, " done"}, int'(bus.tx_done_tick), 1);
        chk({nm, " idle"}, int'({bus.tx, bus.tx_ready}), 3);
        if (exp_par >= 0)
            chk({nm, " parity"}, int'(act[6 + int'(db)]), exp_par);
        if (!hold_next) begin
            bus.tx_valid = 1'b0;
            step(1'b0);
            chk({nm, " done_clr"}, int'(bus.tx_done_tick), 0);
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [7:0]  rd;
        logic [1:0]  rdb, rpm;
        logic        rsb;
        int nb, w, errs;

        bus.s_tick      = 1'b0;
        bus.tx_valid    = 1'b0;
        bus.din         = '0;
        bus.data_bits   = 2'b11;
        bus.parity_mode = 2'b00;
        bus.stop_bits   = 1'b0;

        vt[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 160, -1, 0, -1, 1'b0};
        vt[1] = '{8'h35, 2'b10, 2'b01, 1'b0, 160,  0, 0, -1, 1'b0};
        vt[2] = '{8'h35, 2'b10, 2'b10, 1'b0, 160,  1, 0, -1, 1'b0};
        vt[3] = '{8'hB5, 2'b10, 2'b10, 1'b0, 160,  1, 0, -1, 1'b0};
        vt[4] = '{8'hFF, 2'b00, 2'b10, 1'b1, 144,  0, 0, -1, 1'b0};
        vt[5] = '{8'h35, 2'b10, 2'b01, 1'b0, 160,  0, 1, 40, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'({bus.tx, bus.tx_ready, bus.tx_busy,
                                 bus.tx_done_tick}), 4'b1100);
        reset_in = 1'b1;

        foreach (vt[i])
            run_frame(vt[i].d, vt[i].db, vt[i].pm, vt[i].sb, vt[i].ticks,
                      vt[i].par, vt[i].gap_max, vt[i].long_gap, vt[i].noise,
                      1'b0, 8'h00, $sformatf("vec%0d", i), w);

        run_frame(8'h00, 2'b11, 2'b00, 1'b0, 160, -1, 0, -1, 1'b0,
                  1'b1, 8'hFF, "b2b_first", w);
        run_frame(8'hFF, 2'b11, 2'b00, 1'b0, 160, -1, 0, -1, 1'b0,
                  1'b0, 8'h00, "b2b_second", w);
        chk("b2b_idle_cycles", w, 0);

        bus.tx_valid  = 1'b1;
        bus.din       = 8'h00;
        bus.data_bits = 2'b11;
        bus.parity_mode = 2'b00;
        bus.stop_bits = 1'b0;
        step(1'b0);
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 3 * OS; i++) step(1'b1);
        chk("rst_pre_data", int'({bus.tx, bus.tx_busy}), 1);
        #2 reset_in = 1'b0;
        #1;
        chk("rst_async", int'({bus.tx, bus.tx_ready, bus.tx_busy,
                               bus.tx_done_tick}), 4'b1100);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            if (bus.tx_done_tick || !bus.tx) errs++;
        end
        reset_in = 1'b1;
        for (int i = 0; i < 2 * OS; i++) begin
            step(1'b1);
            if (bus.tx_done_tick) errs++;
        end
        chk("rst_no_done", errs, 0);
        run_frame(8'h5A, 2'b11, 2'b00, 1'b0, 160, -1, 0, -1, 1'b0,
                  1'b0, 8'h00, "post_reset", w);

        for (int r = 0; r < 20; r++) begin
            rd  = 8'($urandom);
            rdb = 2'($urandom);
            rpm = 2'($urandom);
            rsb = 1'($urandom);
            model(rd, rdb, rpm, rsb, bits, nb);
            run_frame(rd, rdb, rpm, rsb, nb * OS, -1, 1, -1, 1'b0,
                      1'b0, 8'h00, $sformatf("rand%0d", r), w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
